// File: rtl/lad_pkg.sv
// lad_pkg: state type and bus constants shared by the lad_port slice.
package lad_pkg;
   typedef enum logic [2:0] {IDLE, TX_LO, TX_HI, TAR, RX_LO, RX_HI, DONE} lad_state_t;
   localparam int NIBBLE_W = 4;
   localparam logic [NIBBLE_W-1:0] BUS_IDLE = 4'hF;
endpackage

// File: rtl/lad_port_sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, meta} <= '0;
      else        {q, meta} <= {meta, d};
endmodule

// File: rtl/lad_port.sv
// lad_port: half-duplex 4-bit bus port; sends bytes as nibble slots, turns the bus
// around and captures a requested number of response bytes.
module lad_port
   import lad_pkg::*;
#(
   parameter int NIBBLE_CYCLES = 8,
   parameter int TAR_SLOTS     = 2
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic [NIBBLE_W-1:0] pin_in,
   output logic [NIBBLE_W-1:0] pin_out,
   output logic                pin_oe,
   input  logic                tx_valid,
   input  logic [7:0]          tx_data,
   input  logic                tx_last,
   output logic                tx_ready,
   input  logic [3:0]          rx_count,
   output logic                rx_valid,
   output logic [7:0]          rx_data,
   output logic                busy,
   output logic                done
);
   localparam int CW = $clog2(NIBBLE_CYCLES);
   localparam logic [CW-1:0] SLOT_LAST = CW'(NIBBLE_CYCLES - 1);
   localparam logic [3:0] TAR_LAST = 4'(TAR_SLOTS - 1);
   lad_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0] tar_cnt, rem, rem_n, lo;
   logic [7:0] tx_byte, byte_n;
   logic last, last_n, slot_end, accept, rx_hi_smp;
   logic [NIBBLE_W-1:0] pin_sync;
   sync_2ff #(.W(NIBBLE_W)) u_sync (
      .clk  (CLK100MHZ),
      .rst_n(CPU_RESETN),
      .d    (pin_in),
      .q    (pin_sync)
   );
   always_comb begin
      slot_end  = cnt == SLOT_LAST;
      accept    = tx_valid && tx_ready;
      rx_hi_smp = state == RX_HI && slot_end && rem != 4'd0;
      byte_n    = accept ? tx_data : tx_byte;
      last_n    = accept ? tx_last : last;
      rem_n     = (state == IDLE && accept) ? rx_count : rx_hi_smp ? rem - 4'd1 : rem;
      state_n   = state;
      case (state)
         IDLE:  if (accept) state_n = TX_LO;
         TX_LO: if (slot_end) state_n = TX_HI;
         // a non-last byte with no successor holds the high nibble (stall)
         TX_HI: if (slot_end && (last || accept)) state_n = !last ? TX_LO : (rem != 4'd0) ? TAR : DONE;
         TAR:   if (slot_end && tar_cnt == TAR_LAST) state_n = RX_LO;
         RX_LO: if (slot_end) state_n = RX_HI;
         // after the final sample RX_HI holds one cycle so done trails rx_valid
         RX_HI: if (rem == 4'd0) state_n = DONE;
                else if (slot_end && rem != 4'd1) state_n = RX_LO;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      cnt_n = (state_n != state || (slot_end && state == TAR)) ? '0 : slot_end ? cnt : cnt + 1'b1;
   end
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state    <= IDLE;
         cnt      <= '0;
         tar_cnt  <= '0;
         rem      <= '0;
         lo       <= '0;
         tx_byte  <= '0;
         last     <= 1'b0;
         pin_oe   <= 1'b0;
         pin_out  <= BUS_IDLE;
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         tar_cnt  <= state != TAR ? 4'd0 : slot_end ? tar_cnt + 4'd1 : tar_cnt;
         rem      <= rem_n;
         tx_byte  <= byte_n;
         last     <= last_n;
         if (state == RX_LO && slot_end) lo <= pin_sync;
         pin_oe   <= state_n == TX_LO || state_n == TX_HI;
         pin_out  <= state_n == TX_LO ? byte_n[3:0] : state_n == TX_HI ? byte_n[7:4] : BUS_IDLE;
         tx_ready <= state_n == IDLE || (state_n == TX_HI && cnt_n == SLOT_LAST && !last_n);
         rx_valid <= rx_hi_smp;
         if (rx_hi_smp) rx_data <= {pin_sync, lo};
         busy     <= state_n != IDLE;
         done     <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_lad_port.sv
// tb_lad_port: per-cycle expectation tables built from the bus timing rules, plus reset corner cases.
module tb_lad_port;
   localparam int N = 4;
   localparam int T = 2;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] pin_in = 4'h0, pin_out, rx_count = 4'h0;
   logic pin_oe, tx_valid = 1'b0, tx_last = 1'b0, tx_ready, rx_valid, busy, done;
   logic [7:0] tx_data = 8'h00, rx_data;
   always #5 clk = ~clk;
   lad_port #(.NIBBLE_CYCLES(N), .TAR_SLOTS(T)) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
      .rx_count(rx_count), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done)
   );
   typedef struct {
      logic tv; logic [7:0] td; logic tl; logic [3:0] rc; logic [3:0] pin; logic glitch; logic [3:0] good;
      logic oe; logic [3:0] out; logic rdy; logic rxv; logic [7:0] rxd; logic bsy; logic dn;
   } cyc_t;
   cyc_t q[$];
   int checks = 0, errors = 0;
   logic [7:0] txb[8];
   logic [7:0] rxb[16];
   int st[8];
   function automatic cyc_t mk(logic oe, logic [3:0] out, logic rdy, logic bsy);
      cyc_t c;
      c.tv = 1'b0; c.td = 8'($urandom); c.tl = 1'($urandom); c.rc = 4'($urandom);
      c.pin = 4'($urandom); c.glitch = 1'b0; c.good = c.pin;
      c.oe = oe; c.out = out; c.rdy = rdy; c.rxv = 1'b0; c.rxd = 8'h00; c.bsy = bsy; c.dn = 1'b0;
      return c;
   endfunction
   // one transaction: accept cycle, TX slots (with stalls), then done or TAR + RX, then an idle cycle
   task automatic build(int n, int m);
      cyc_t c;
      int s;
      logic [3:0] nib;
      c = mk(1'b0, 4'hF, 1'b1, 1'b0);
      c.tv = 1'b1; c.td = txb[0]; c.tl = (n == 1); c.rc = 4'(m);
      q.push_back(c);
      for (int i = 0; i < n; i++) begin
         s = (i < n - 1) ? st[i+1] : 0;
         for (int k = 0; k < N; k++) begin
            c = mk(1'b1, txb[i][3:0], 1'b0, 1'b1);
            if (i < n - 1) begin c.tv = 1'b1; c.td = txb[i+1]; c.tl = (i + 1 == n - 1); end
            q.push_back(c);
         end
         for (int k = 0; k < N + s; k++) begin
            c = mk(1'b1, txb[i][7:4], (i < n - 1) && k >= N - 1, 1'b1);
            if (i < n - 1) begin
               c.tv = !(k >= N - 1 && k < N - 1 + s); c.td = txb[i+1]; c.tl = (i + 1 == n - 1);
            end
            q.push_back(c);
         end
      end
      if (m != 0) begin
         for (int k = 0; k < T * N; k++) q.push_back(mk(1'b0, 4'hF, 1'b0, 1'b1));
         for (int j = 0; j < m; j++)
            for (int k = 0; k < 2 * N; k++) begin
               c = mk(1'b0, 4'hF, 1'b0, 1'b1);
               nib = k < N ? rxb[j][3:0] : rxb[j][7:4];
               c.good = nib; c.glitch = (k % N == 0);
               if (k % N != 0) c.pin = nib;
               if (j > 0 && k == 0) begin c.rxv = 1'b1; c.rxd = rxb[j-1]; end
               q.push_back(c);
            end
         c = mk(1'b0, 4'hF, 1'b0, 1'b1); c.rxv = 1'b1; c.rxd = rxb[m-1];
         q.push_back(c);
      end
      c = mk(1'b0, 4'hF, 1'b0, 1'b1); c.dn = 1'b1;
      q.push_back(c);
      q.push_back(mk(1'b0, 4'hF, 1'b1, 1'b0));
   endtask
   task automatic run(string nm, int stop);
      for (int i = 0; i < q.size() && i <= stop; i++) begin
         @(posedge clk); #1;
         tx_valid = q[i].tv; tx_data = q[i].td; tx_last = q[i].tl; rx_count = q[i].rc; pin_in = q[i].pin;
         checks++;
         if ({pin_oe, pin_out, tx_ready, rx_valid, busy, done} !== {q[i].oe, q[i].out, q[i].rdy, q[i].rxv, q[i].bsy, q[i].dn}
             || (q[i].rxv && rx_data !== q[i].rxd)) begin
            errors++;
            $display("FAIL %s cyc %0d oe/out/rdy/rxv/busy/done/rxd got %b/%h/%b/%b/%b/%b/%h want %b/%h/%b/%b/%b/%b/%h",
                     nm, i, pin_oe, pin_out, tx_ready, rx_valid, busy, done, rx_data,
                     q[i].oe, q[i].out, q[i].rdy, q[i].rxv, q[i].bsy, q[i].dn, q[i].rxd);
         end
         if (q[i].glitch) begin #($urandom_range(1, 7)); pin_in = q[i].good; end
      end
      q.delete();
   endtask
   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s got %h want %h", nm, act, exp); end
   endtask
   initial begin
      #12;
      chk("rst_oe", 8'(pin_oe), 8'h0);    chk("rst_out", 8'(pin_out), 8'hF);
      chk("rst_rdy", 8'(tx_ready), 8'h0); chk("rst_rxv", 8'(rx_valid), 8'h0);
      chk("rst_rxd", rx_data, 8'h00);     chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_done", 8'(done), 8'h0);
      @(negedge clk) rst_n = 1'b1;
      txb[0] = 8'hA5; build(1, 0); run("single", 1 << 30);
      txb[0] = 8'h12; txb[1] = 8'h34; st[1] = 0; build(2, 0); run("b2b", 1 << 30);
      txb[0] = 8'h0B; rxb[0] = 8'hC6; rxb[1] = 8'h0F; build(1, 2); run("txrx", 1 << 30);
      txb[0] = 8'h5E; txb[1] = 8'hD7; st[1] = 10; build(2, 0); run("underrun", 1 << 30);
      txb[0] = 8'h3C; rxb[0] = 8'h99; rxb[1] = 8'h42; build(1, 2);
      run("pre_rst", 1 + 2 * N + T * N + 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_oe", 8'(pin_oe), 8'h0); chk("mid_rst_busy", 8'(busy), 8'h0);
      chk("mid_rst_rxv", 8'(rx_valid), 8'h0); chk("mid_rst_rxd", rx_data, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rdy", 8'(tx_ready), 8'h1); chk("post_rst_busy", 8'(busy), 8'h0);
      for (int t = 0; t < 20; t++) begin
         int n, m;
         n = $urandom_range(1, 4);
         m = (t == 7) ? 15 : $urandom_range(0, 3);
         for (int i = 0; i < 8; i++) begin txb[i] = 8'($urandom); st[i] = $urandom_range(0, 3); end
         for (int j = 0; j < 16; j++) rxb[j] = 8'($urandom);
         build(n, m);
         run("rand", 1 << 30);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lad_port.md
# lad_port

Half-duplex 4-bit bus port that sits directly upstream of the tristate pad logic on PMOD header `ja`. It turns a byte stream from the protocol layer into nibble slots driven onto the bus, then releases the bus for a turnaround and captures a requested number of response bytes. The pad level consumes only `pin_out` and `pin_oe`, and returns the raw `pin_in`.

## Interface
- `NIBBLE_CYCLES`, default 8: clock cycles per nibble slot; legal values are 4..255.
- `TAR_SLOTS`, default 2: turnaround slots with the bus released, between TX and RX; legal values are 1..15.

Ports:
- `CLK100MHZ` in 1: sole clock.
- `CPU_RESETN` in 1: reset, asynchronous, active-low.
- `pin_in` in 4: raw bus value from the pad; asynchronous.
- `pin_out` out 4: value to drive on the bus.
- `pin_oe` out 1: drive enable for the pad; 1 means drive `pin_out`, 0 means Z.
- `tx_valid` in 1: upstream byte valid.
- `tx_data` in 8: byte to send.
- `tx_last` in 1: marks the final TX byte of the transaction.
- `tx_ready` out 1: port accepts `tx_data` this cycle.
- `rx_count` in 4: response bytes to read; sampled with the first TX byte. 0 means no RX phase.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_data` out 8: received byte.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.

## Operation
- All outputs are registered. Reset values: `pin_oe`=0, `pin_out`=4'hF, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, `done`=0. The state is IDLE.
- Asserting reset in any state immediately (asynchronously) drops `pin_oe` to 0. The partial transaction is discarded.
- `pin_in` passes through the 2-flop synchronizer before any use.
- States are IDLE, TX_LO, TX_HI, TAR, RX_LO, RX_HI and DONE.
- IDLE:
  - `tx_ready`=1.
  - On `tx_valid`&&`tx_ready`, latch `tx_data`, `tx_last` and `rx_count`, then go to TX_LO.
- TX_LO and TX_HI:
  - `pin_oe`=1.
  - `pin_out` carries the low nibble, then the high nibble.
  - Each state lasts one slot.
- End of TX_HI:
  - If the latched last flag is 0, `tx_ready`=1 in the final slot cycle.
  - On accept, load the next byte and go to TX_LO.
  - If `tx_valid`=0, stay in TX_HI holding the bus (stall) until a byte arrives. Underrun stretches the high-nibble slot.
  - If the last flag is 1: go to TAR when `rx_count`≠0, otherwise go to DONE.
- TAR:
  - `pin_oe`=0 and `pin_out`=4'hF.
  - Lasts `TAR_SLOTS` slots, then goes to RX_LO.
- RX_LO and RX_HI:
  - `pin_oe`=0.
  - The synchronized input is sampled in the final cycle of each slot. The low nibble is first.
  - After RX_HI, assemble `{hi,lo}`, pulse `rx_valid`, and decrement the remaining count.
  - Go to RX_LO if the count is nonzero, otherwise go to DONE.
- DONE:
  - Lasts one cycle, with `done`=1 and `pin_oe`=0.
  - Then returns to IDLE.
- `busy`=1 in every state except IDLE.
- `tx_ready` is never asserted outside IDLE or the final cycle of TX_HI.
- `rx_count` changes mid-transaction are ignored.

## Timing
- Accept in cycle 0:
  - `pin_oe`=1 and `pin_out`=low nibble from cycle 1.
  - High nibble from cycle 1+`NIBBLE_CYCLES`.
- Next-byte accept in cycle 2·`NIBBLE_CYCLES`. Its low nibble appears in cycle 2·`NIBBLE_CYCLES`+1. There are no gap cycles between bytes.
- `pin_oe` falls in the first TAR cycle. The pad sees no cycle with both sides driving from this block.
- RX sampling uses the synchronizer output, so bus data must be stable at least 3 cycles before the slot end. This is why `NIBBLE_CYCLES`≥4.
- `rx_valid` is asserted in the cycle after the RX_HI sample cycle.
- `done` is asserted in the cycle after the last TX_HI slot, or after the last `rx_valid`.
- One-byte TX with no RX occupies 2·`NIBBLE_CYCLES` cycles from accept, plus DONE.

## Structure
- Package `lad_pkg` holds:
  - The `lad_state_t` enum.
  - `NIBBLE_W`=4.
  - The idle bus value 4'hF.
- Slot counter: width `$clog2(NIBBLE_CYCLES)`, reloads on every state change. TAR uses a separate slot counter.
- Sub-module `sync_2ff` is a parameterized-width 2-flop synchronizer, instantiated with width 4.

## Test plan
All tests use `NIBBLE_CYCLES`=4 and `TAR_SLOTS`=2.
- Single byte, no RX: send 8'hA5 with `tx_last`=1 and `rx_count`=0.
  - Expect `pin_out`=5 for cycles 1-4, then A for cycles 5-8, with `pin_oe`=1.
  - Expect `done` in cycle 9, then IDLE.
- Back-to-back TX: send 8'h12 and 8'h34 with `tx_valid` held.
  - Expect the nibble sequence 2,1,4,3 with no gap cycles and `pin_oe` continuously 1.
- TX then RX: send 8'h0B (last), `rx_count`=2; the bench drives `pin_in` with 6,C then F,0 in the RX slots.
  - Expect `pin_oe`=0 for the 8 TAR cycles.
  - Expect `rx_valid` pulses with 8'hC6 then 8'h0F, then `done`.
- Underrun: drop `tx_valid` for 10 cycles after the first non-last byte.
  - Expect TX_HI to extend by 10 cycles with `pin_oe`=1 and the high nibble held.
  - The second byte then proceeds normally.
- Reset mid-RX: assert `CPU_RESETN`=0 during RX_LO.
  - Expect `pin_oe`=0, `busy`=0 and `rx_valid`=0 in the same cycle.
  - After release, `tx_ready`=1.
- Metastability: toggle `pin_in` asynchronously at slot start.
  - Expect the sampled value to equal the level held during the final 3 slot cycles.
